// File: rtl/rlwe_dmem_arb.sv
// rtl/rlwe_dmem_arb.sv - two-requester DMEM arbiter (scalar LSU, RLWE vector unit)
// One outstanding transaction, round-robin with grant lock, response timeout.
module rlwe_dmem_arb #(
   parameter int  LANE = 16,
   parameter int  AW   = 32,
   parameter int  TMO  = 512,
   localparam int DW   = 32*LANE,
   localparam int TW   = $clog2(TMO)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_cmd,
   input  logic [1:0]    m0_width,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_req_ack,
   output logic [DW-1:0] m0_rdata,
   output logic [1:0]    m0_resp,
   input  logic          m1_req,
   input  logic          m1_cmd,
   input  logic [1:0]    m1_width,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_req_ack,
   output logic [DW-1:0] m1_rdata,
   output logic [1:0]    m1_resp,
   output logic          dmem_req,
   output logic          dmem_cmd,
   output logic [1:0]    dmem_width,
   output logic [AW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic          dmem_req_ack,
   input  logic [DW-1:0] dmem_rdata,
   input  logic [1:0]    dmem_resp,
   output logic          err_unexp,
   output logic          err_tmo
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t        state, state_d;
   logic          owner, owner_d;
   logic          last, last_d;
   logic          lock_vld, lock_vld_d;
   logic          lock_id, lock_id_d;
   logic [TW-1:0] timer, timer_d;
   logic          err_unexp_d;
   logic          gnt_vld, gnt_id, lock_hold;
   logic [1:0]    own_resp;
   logic [DW-1:0] own_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         owner     <= 1'b0;
         last      <= 1'b1;
         lock_vld  <= 1'b0;
         lock_id   <= 1'b0;
         timer     <= '0;
         err_unexp <= 1'b0;
      end else begin
         state     <= state_d;
         owner     <= owner_d;
         last      <= last_d;
         lock_vld  <= lock_vld_d;
         lock_id   <= lock_id_d;
         timer     <= timer_d;
         err_unexp <= err_unexp_d;
      end
   end

   always_comb begin
      state_d     = state;
      owner_d     = owner;
      last_d      = last;
      lock_vld_d  = lock_vld;
      lock_id_d   = lock_id;
      timer_d     = timer;
      err_unexp_d = err_unexp;
      gnt_vld     = 1'b0;
      gnt_id      = 1'b0;
      own_resp    = 2'd0;
      own_rdata   = '0;
      err_tmo     = 1'b0;
      dmem_req    = 1'b0;
      dmem_cmd    = 1'b0;
      dmem_width  = 2'd0;
      dmem_addr   = '0;
      dmem_wdata  = '0;
      m0_req_ack  = 1'b0;
      m1_req_ack  = 1'b0;
      m0_resp     = 2'd0;
      m1_resp     = 2'd0;
      m0_rdata    = '0;
      m1_rdata    = '0;
      // A lock only survives while its requester keeps req asserted
      lock_hold   = lock_vld & (lock_id ? m1_req : m0_req);

      if (state == S_IDLE) begin
         if (lock_hold) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id;
         end else if (m0_req && m1_req) begin
            gnt_vld = 1'b1;
            gnt_id  = ~last;
         end else if (m0_req || m1_req) begin
            gnt_vld = 1'b1;
            gnt_id  = m1_req;
         end
         dmem_req = m0_req | m1_req;
         if (gnt_vld) begin
            dmem_cmd   = gnt_id ? m1_cmd   : m0_cmd;
            dmem_width = gnt_id ? m1_width : m0_width;
            dmem_addr  = gnt_id ? m1_addr  : m0_addr;
            dmem_wdata = gnt_id ? m1_wdata : m0_wdata;
         end
         m0_req_ack = gnt_vld & ~gnt_id & dmem_req_ack;
         m1_req_ack = gnt_vld &  gnt_id & dmem_req_ack;
         if (dmem_resp != 2'd0)
            err_unexp_d = 1'b1;
         if (gnt_vld && dmem_req_ack) begin
            state_d    = S_BUSY;
            owner_d    = gnt_id;
            last_d     = gnt_id;
            lock_vld_d = 1'b0;
            timer_d    = '0;
         end else begin
            lock_vld_d = gnt_vld;
            lock_id_d  = gnt_id;
         end
      end else begin
         own_rdata = dmem_rdata;
         if (dmem_resp != 2'd0) begin
            // Encoding 3 is not defined by DMEM; report it as an error
            own_resp = (dmem_resp == 2'd3) ? 2'd2 : dmem_resp;
            state_d  = S_IDLE;
         end else if (timer == TW'(TMO-1)) begin
            own_resp  = 2'd2;
            own_rdata = '0;
            err_tmo   = 1'b1;
            state_d   = S_IDLE;
         end else begin
            timer_d = timer + TW'(1);
         end
         if (owner) begin
            m1_resp  = own_resp;
            m1_rdata = own_rdata;
         end else begin
            m0_resp  = own_resp;
            m0_rdata = own_rdata;
         end
      end

      if (rst) begin
         err_tmo    = 1'b0;
         dmem_req   = 1'b0;
         dmem_cmd   = 1'b0;
         dmem_width = 2'd0;
         dmem_addr  = '0;
         dmem_wdata = '0;
         m0_req_ack = 1'b0;
         m1_req_ack = 1'b0;
         m0_resp    = 2'd0;
         m1_resp    = 2'd0;
         m0_rdata   = '0;
         m1_rdata   = '0;
      end
   end

endmodule

// File: tb/tb_rlwe_dmem_arb.sv
// tb/tb_rlwe_dmem_arb.sv - self-checking bench for rlwe_dmem_arb
// Grants and responses are scored against queues filled as stimulus is driven.
module tb_rlwe_dmem_arb;

   localparam int LANE = 16;
   localparam int AW   = 32;
   localparam int DW   = 32*LANE;

   typedef struct {
      int            id;
      logic [1:0]    resp;
      logic [DW-1:0] rdata;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_cmd, m0_req_ack;
   logic [1:0]    m0_width, m0_resp;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_cmd, m1_req_ack;
   logic [1:0]    m1_width, m1_resp;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          dmem_req, dmem_cmd, dmem_req_ack;
   logic [1:0]    dmem_width, dmem_resp;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata, dmem_rdata;
   logic          err_unexp, err_tmo;

   int   checks = 0;
   int   errors = 0;
   int   gnt_q[$];
   exp_t exp_q[$];

   always #5 clk = ~clk;

   rlwe_dmem_arb #(.LANE(LANE), .AW(AW), .TMO(8)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_width(m0_width), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_req_ack(m0_req_ack), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
      .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_width(m1_width), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_req_ack(m1_req_ack), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
      .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata),
      .dmem_resp(dmem_resp), .err_unexp(err_unexp), .err_tmo(err_tmo)
   );

   task automatic sb_check();
      int   g;
      exp_t e;
      int   id;
      if (m0_req_ack === 1'b1 || m1_req_ack === 1'b1) begin
         checks++;
         if (gnt_q.size() == 0) begin
            errors++;
            $display("FAIL sb_grant: ack m0=%b m1=%b, no grant expected", m0_req_ack, m1_req_ack);
         end else begin
            g = gnt_q.pop_front();
            if ((m0_req_ack && m1_req_ack) || int'(m1_req_ack) != g) begin
               errors++;
               $display("FAIL sb_grant: ack m0=%b m1=%b, want grant m%0d", m0_req_ack, m1_req_ack, g);
            end
         end
      end
      if (m0_resp !== 2'd0 || m1_resp !== 2'd0) begin
         checks++;
         id = (m1_resp !== 2'd0) ? 1 : 0;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_resp: m0_resp=%0d m1_resp=%0d, no response expected", m0_resp, m1_resp);
         end else begin
            e = exp_q.pop_front();
            if ((m0_resp !== 2'd0 && m1_resp !== 2'd0) || id != e.id ||
                (id ? m1_resp : m0_resp) !== e.resp || (id ? m1_rdata : m0_rdata) !== e.rdata) begin
               errors++;
               $display("FAIL sb_resp: got m%0d resp=%0d rdata=%h, want m%0d resp=%0d rdata=%h",
                        id, id ? m1_resp : m0_resp, id ? m1_rdata : m0_rdata, e.id, e.resp, e.rdata);
            end
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      sb_check();
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int id, input logic [1:0] resp, input logic [DW-1:0] rdata);
      exp_t e;
      e.id = id; e.resp = resp; e.rdata = rdata;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      m0_req = 1'b1; m1_req = 1'b1; dmem_req_ack = 1'b1; dmem_resp = 2'd2;
      dmem_rdata = {LANE{32'hFFFF0000}};
      sample();
      checks++;
      if ({dmem_req, m0_req_ack, m1_req_ack, err_unexp, err_tmo} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: req/ack0/ack1/unexp/tmo=%b want 00000",
                  {dmem_req, m0_req_ack, m1_req_ack, err_unexp, err_tmo});
      end
      checks++;
      if (m0_resp !== 2'd0 || m1_resp !== 2'd0 || m0_rdata !== '0 || m1_rdata !== '0) begin
         errors++;
         $display("FAIL reset_resp: m0_resp=%0d m1_resp=%0d want 0 with zero rdata", m0_resp, m1_resp);
      end
      next();
      m0_req = 1'b0; m1_req = 1'b0; dmem_req_ack = 1'b0; dmem_resp = 2'd0; dmem_rdata = '0;
      rst = 1'b0;
      sample();
      next();
   endtask

   task automatic test_single_read();
      logic [DW-1:0] rd;
      rd = {LANE{32'hA5A5A5A5}};
      m1_req = 1'b1; m1_cmd = 1'b0; m1_width = 2'd3; m1_addr = 32'h40; dmem_req_ack = 1'b1;
      gnt_q.push_back(1);
      sample();
      checks++;
      if (m1_req_ack !== 1'b1 || dmem_addr !== 32'h40 || dmem_width !== 2'd3 || dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL single_accept: ack=%b addr=%h width=%0d req=%b want 1 40 3 1",
                  m1_req_ack, dmem_addr, dmem_width, dmem_req);
      end
      for (int c = 1; c <= 3; c++) begin
         next();
         m1_req = 1'b0; dmem_req_ack = 1'b0;
         if (c == 3) begin
            dmem_resp = 2'd1; dmem_rdata = rd;
            push_exp(1, 2'd1, rd);
         end
         sample();
         checks++;
         if (m0_resp !== 2'd0 || dmem_req !== 1'b0 || (c < 3 && m1_resp !== 2'd0)) begin
            errors++;
            $display("FAIL single_busy c%0d: m0_resp=%0d m1_resp=%0d dmem_req=%b", c, m0_resp, m1_resp, dmem_req);
         end
      end
      next();
      dmem_resp = 2'd0; dmem_rdata = '0;
      sample();
      next();
   endtask

   task automatic test_alternate();
      logic [DW-1:0] rd;
      int            want;
      m0_req = 1'b1; m1_req = 1'b1; dmem_req_ack = 1'b1;
      m0_addr = 32'h1000; m1_addr = 32'h2000; m0_width = 2'd2; m1_width = 2'd3;
      for (int i = 0; i < 6; i++) begin
         want = i % 2;
         dmem_resp = 2'd0;
         gnt_q.push_back(want);
         sample();
         checks++;
         if (dmem_addr !== (want == 1 ? 32'h2000 : 32'h1000)) begin
            errors++;
            $display("FAIL alt_addr i%0d: got %h want grant m%0d", i, dmem_addr, want);
         end
         next();
         rd = {LANE{32'(i + 1) * 32'h01010101}};
         dmem_resp = (i == 3) ? 2'd3 : 2'd1;
         dmem_rdata = rd;
         push_exp(want, (i == 3) ? 2'd2 : 2'd1, rd);
         sample();
         checks++;
         if (dmem_req !== 1'b0 || m0_req_ack !== 1'b0 || m1_req_ack !== 1'b0) begin
            errors++;
            $display("FAIL alt_busy i%0d: dmem_req=%b ack0=%b ack1=%b want 0", i, dmem_req, m0_req_ack, m1_req_ack);
         end
         next();
      end
      m0_req = 1'b0; m1_req = 1'b0; dmem_req_ack = 1'b0; dmem_resp = 2'd0;
      sample();
      next();
   endtask

   task automatic test_lock();
      logic [DW-1:0] rd;
      m1_req = 1'b1; m1_addr = 32'h100; m0_addr = 32'h200; dmem_req_ack = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) m0_req = 1'b1;
         if (c == 3) begin
            dmem_req_ack = 1'b1;
            gnt_q.push_back(1);
         end
         sample();
         checks++;
         if (dmem_addr !== 32'h100) begin
            errors++;
            $display("FAIL lock_addr c%0d: got %h want 00000100", c, dmem_addr);
         end
         next();
      end
      m1_req = 1'b0; rd = {LANE{32'h0BADF00D}};
      dmem_resp = 2'd2; dmem_rdata = rd;
      push_exp(1, 2'd2, rd);
      sample();
      next();
      dmem_resp = 2'd0;
      gnt_q.push_back(0);
      sample();
      checks++;
      if (dmem_addr !== 32'h200 || m0_req_ack !== 1'b1) begin
         errors++;
         $display("FAIL lock_next: addr=%h ack0=%b want 00000200 1", dmem_addr, m0_req_ack);
      end
      next();
      m0_req = 1'b0; dmem_req_ack = 1'b0; rd = {LANE{32'h00C0FFEE}};
      dmem_resp = 2'd1; dmem_rdata = rd;
      push_exp(0, 2'd1, rd);
      sample();
      next();
      dmem_resp = 2'd0;
      m0_req = 1'b1; m0_addr = 32'h300;
      sample();
      next();
      m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h304; dmem_req_ack = 1'b1;
      gnt_q.push_back(1);
      sample();
      checks++;
      if (dmem_addr !== 32'h304) begin
         errors++;
         $display("FAIL lock_drop: addr=%h want 00000304", dmem_addr);
      end
      next();
      m1_req = 1'b0; dmem_req_ack = 1'b0; rd = {LANE{32'h77777777}};
      dmem_resp = 2'd1; dmem_rdata = rd;
      push_exp(1, 2'd1, rd);
      sample();
      next();
      dmem_resp = 2'd0;
      sample();
      next();
   endtask

   task automatic test_timeout();
      logic [DW-1:0] rd;
      m0_req = 1'b1; m0_cmd = 1'b1; m0_width = 2'd2; m0_addr = 32'h10;
      m0_wdata = {LANE{32'hDEADBEEF}}; dmem_req_ack = 1'b1;
      gnt_q.push_back(0);
      sample();
      checks++;
      if (dmem_cmd !== 1'b1 || dmem_wdata !== {LANE{32'hDEADBEEF}}) begin
         errors++;
         $display("FAIL tmo_write: cmd=%b wdata=%h", dmem_cmd, dmem_wdata);
      end
      next();
      m0_req = 1'b0; m0_cmd = 1'b0; dmem_req_ack = 1'b0;
      dmem_rdata = {LANE{32'h12345678}};
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) push_exp(0, 2'd2, '0);
         sample();
         checks++;
         if (err_tmo !== (k == 8)) begin
            errors++;
            $display("FAIL tmo_pulse k%0d: err_tmo=%b want %0d", k, err_tmo, k == 8);
         end
         next();
      end
      m1_req = 1'b1; m1_addr = 32'h44; dmem_req_ack = 1'b1;
      gnt_q.push_back(1);
      sample();
      checks++;
      if (err_tmo !== 1'b0 || m1_req_ack !== 1'b1) begin
         errors++;
         $display("FAIL tmo_after: err_tmo=%b ack1=%b want 0 1", err_tmo, m1_req_ack);
      end
      next();
      m1_req = 1'b0; dmem_req_ack = 1'b0; rd = {LANE{32'h5A5A5A5A}};
      dmem_resp = 2'd1; dmem_rdata = rd;
      push_exp(1, 2'd1, rd);
      sample();
      next();
      dmem_resp = 2'd0; dmem_rdata = '0;
      sample();
      next();
   endtask

   task automatic test_unexp();
      checks++;
      if (err_unexp !== 1'b0) begin
         errors++;
         $display("FAIL unexp_pre: err_unexp=%b want 0", err_unexp);
      end
      dmem_resp = 2'd1; dmem_rdata = {LANE{32'h11111111}};
      sample();
      checks++;
      if (m0_resp !== 2'd0 || m1_resp !== 2'd0 || err_unexp !== 1'b0) begin
         errors++;
         $display("FAIL unexp_fwd: m0_resp=%0d m1_resp=%0d err_unexp=%b want 0 0 0", m0_resp, m1_resp, err_unexp);
      end
      next();
      dmem_resp = 2'd0; dmem_rdata = '0;
      for (int c = 0; c < 3; c++) begin
         sample();
         checks++;
         if (err_unexp !== 1'b1) begin
            errors++;
            $display("FAIL unexp_sticky c%0d: err_unexp=%b want 1", c, err_unexp);
         end
         next();
      end
   endtask

   task automatic test_reset_busy();
      logic [DW-1:0] rd;
      m0_req = 1'b1; m0_cmd = 1'b0; m0_width = 2'd2; m0_addr = 32'h80; dmem_req_ack = 1'b1;
      gnt_q.push_back(0);
      sample();
      next();
      m0_req = 1'b0; m1_req = 1'b1; dmem_resp = 2'd1; dmem_rdata = {LANE{32'h99999999}};
      #1 rst = 1'b1;
      #1;
      checks++;
      if (m0_resp !== 2'd0 || m0_rdata !== '0 || dmem_req !== 1'b0 || m1_req_ack !== 1'b0 || err_unexp !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: m0_resp=%0d dmem_req=%b ack1=%b err_unexp=%b want all 0",
                  m0_resp, dmem_req, m1_req_ack, err_unexp);
      end
      sample();
      next();
      rst = 1'b0; m1_req = 1'b0; dmem_req_ack = 1'b0;
      sample();
      checks++;
      if (m0_resp !== 2'd0 || err_unexp !== 1'b0) begin
         errors++;
         $display("FAIL rst_late_resp: m0_resp=%0d err_unexp=%b want 0 0", m0_resp, err_unexp);
      end
      next();
      dmem_resp = 2'd0; dmem_rdata = '0;
      sample();
      checks++;
      if (err_unexp !== 1'b1) begin
         errors++;
         $display("FAIL rst_unexp: err_unexp=%b want 1", err_unexp);
      end
      next();
      m0_req = 1'b1; dmem_req_ack = 1'b1;
      gnt_q.push_back(0);
      sample();
      checks++;
      if (m0_req_ack !== 1'b1) begin
         errors++;
         $display("FAIL rst_reacc: ack0=%b want 1", m0_req_ack);
      end
      next();
      m0_req = 1'b0; dmem_req_ack = 1'b0; rd = {LANE{32'h3C3C3C3C}};
      dmem_resp = 2'd1; dmem_rdata = rd;
      push_exp(0, 2'd1, rd);
      sample();
      next();
      dmem_resp = 2'd0;
      sample();
      next();
   endtask

   initial begin
      rst = 1'b1;
      m0_req = 1'b0; m0_cmd = 1'b0; m0_width = 2'd0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_cmd = 1'b0; m1_width = 2'd0; m1_addr = '0; m1_wdata = '0;
      dmem_req_ack = 1'b0; dmem_rdata = '0; dmem_resp = 2'd0;
      test_reset();
      test_single_read();
      test_alternate();
      test_lock();
      test_timeout();
      test_unexp();
      test_reset_busy();
      checks++;
      if (gnt_q.size() != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d grants and %0d responses never seen, want 0 0", gnt_q.size(), exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rlwe_dmem_arb.md
RLWE_DMEM_ARB -- requirements
Module: rlwe_dmem_arb

Interface
REQ-001 Parameter LANE, default 16, sets the number of 32-bit lanes per vector; data width DW = 32*LANE.
REQ-002 Parameter AW, default 32, sets the DMEM address width.
REQ-003 Parameter TMO, default 512, sets the response-timeout limit in cycles (TMO >= 2).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 For each requester mN, N in {0,1} (m0 = scalar LSU, m1 = RLWE vector unit), the ports are:
- mN_req  in  1  request valid.
- mN_cmd  in  1  0 = RD, 1 = WR.
- mN_width  in  2  0 = BYTE, 1 = HWORD, 2 = WORD, 3 = VECTOR.
- mN_addr  in  AW  request address.
- mN_wdata  in  DW  store data.
- mN_req_ack  out  1  request accepted.
- mN_rdata  out  DW  load data.
- mN_resp  out  2  0 = IDLE, 1 = RDY_OK, 2 = RDY_ER.
REQ-007 The DMEM side ports are:
- dmem_req  out  1  request valid.
- dmem_cmd  out  1  0 = RD, 1 = WR.
- dmem_width  out  2  encoding as mN_width.
- dmem_addr  out  AW  request address.
- dmem_wdata  out  DW  store data.
- dmem_req_ack  in  1  request accepted.
- dmem_rdata  in  DW  load data.
- dmem_resp  in  2  encoding as mN_resp.
REQ-008 Status outputs:
- err_unexp  out  1  sticky flag: a response arrived while IDLE.
- err_tmo  out  1  one-cycle pulse on timeout.

Function
REQ-009 FSM states: IDLE and BUSY; a single transaction is outstanding at most.
REQ-010 IDLE arbitration:
- Only one mN_req high: grant that requester.
- Both high: grant the requester not recorded in register last; reset value of last = 1, so m0 wins the first tie.
REQ-011 Grant lock: when dmem_req is high and dmem_req_ack is low, the grant is held in register lock_vld/lock_id on the next cycle while the locked requester's req stays high.
REQ-012 If the locked requester drops req, the lock clears and arbitration restarts in that cycle.
REQ-013 In IDLE, dmem_req = (m0_req | m1_req), and dmem_cmd/width/addr/wdata combinationally mux the granted requester's fields.
REQ-014 With no grant, dmem_cmd/width/addr/wdata drive 0.
REQ-015 mN_req_ack = IDLE & grant==N & dmem_req_ack; mN_req_ack is never high for both requesters in one cycle.
REQ-016 On an accepted cycle (dmem_req & dmem_req_ack), the next cycle has: state = BUSY, owner = grant, last = grant, lock cleared, timer = 0.
REQ-017 In BUSY, dmem_req = 0 and both mN_req_ack = 0; requests wait.
REQ-018 In BUSY, owner's mN_resp = dmem_resp and mN_rdata = dmem_rdata; the non-owner sees resp IDLE and rdata 0.
REQ-019 In BUSY, when dmem_resp is RDY_OK or RDY_ER, the next state is IDLE; a new request can be accepted in the cycle after the response (1 idle turnaround).
REQ-020 In BUSY, the timer increments every cycle without a response.
REQ-021 When timer == TMO-1 with no response, the owner gets mN_resp = RDY_ER and mN_rdata = 0 that cycle, err_tmo pulses, and the next state is IDLE.
REQ-022 In IDLE, dmem_resp != IDLE sets err_unexp to 1, held until reset; the response is not forwarded and both mN_resp = IDLE.
REQ-023 dmem_resp value 3 is treated as RDY_ER.
REQ-024 Outputs are combinational from state and inputs; acceptance latency is 0 cycles (same-cycle ack pass-through).

Reset
REQ-025 While rst = 1, outputs are forced: state = IDLE, owner = 0, last = 1, lock_vld = 0, timer = 0, err_unexp = 0, err_tmo = 0, dmem_req = 0, all mN_req_ack = 0, all mN_resp = IDLE, all mN_rdata = 0.
REQ-026 Reset asserted mid-transaction abandons the transaction: no response is delivered to the owner, and any DMEM response arriving after reset release sets err_unexp.

Verification
REQ-027 Scenario 1:
- Stimulus: m1 alone, RD VECTOR at addr 0x40, ack at cycle 0, dmem_resp = RDY_OK with rdata = 0xA5.. at cycle 3.
- Required: m1_req_ack = 1 at cycle 0; m1_resp = RDY_OK and m1_rdata = 0xA5.. at cycle 3; m0_resp = IDLE throughout.
REQ-028 Scenario 2:
- Stimulus: m0 and m1 request continuously, memory always acks and responds 1 cycle after accept.
- Required: grants alternate m0, m1, m0, m1, ..., starting with m0.
REQ-029 Scenario 3:
- Stimulus: m1 granted with dmem_req_ack = 0 for 3 cycles while m0 raises req in cycle 1.
- Required: dmem_addr stays at m1's address until ack; m0 is served next.
REQ-030 Scenario 4:
- Stimulus: TMO = 8, m0 WR accepted, no response.
- Required: 8th BUSY cycle gives m0_resp = RDY_ER and err_tmo = 1 for one cycle; the next cycle is IDLE.
REQ-031 Scenario 5:
- Stimulus: dmem_resp = RDY_OK while IDLE.
- Required: err_unexp = 1 from the next cycle until rst; m0_resp = m1_resp = IDLE.
REQ-032 Scenario 6:
- Stimulus: rst pulsed during BUSY.
- Required: all outputs take REQ-025 values immediately, asynchronously; after release, an m0 request is acked normally.
